booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
Sequential, parametrised radix-2 Booth multiplier for signed two's-complement operands of WIDTH bits. It produces a 2*WIDTH-bit signed product.
- Processes one Booth recoding step per clock.
- Uses a start/busy/done handshake, so it can hang off any controller or datapath in the Booth arithmetic library.
- Supersedes the fixed 4-bit combinational multiplier with a width-generic, clocked, handshaked unit.

Parameters:
WIDTH, 8, operand width in bits (>=2); product width is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived, not to be overridden).

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when not busy
multiplicand  input  WIDTH  signed operand M, sampled on accepted start
multiplier  input  WIDTH  signed operand Q, sampled on accepted start
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle pulse, product valid
product  output  2*WIDTH  signed result, held until the next accepted start

Behaviour:
- Reset is synchronous and active-high: when rst is high at a rising edge of clk, the block resets.
  - Resulting state: IDLE, busy=0, done=0, product=0, counter=0, internal registers cleared.
  - Reset overrides start and aborts any in-progress multiplication; no done pulse follows.
- States:
  - IDLE: waiting for a request.
  - RUN: performing Booth steps.
  - DONE: single cycle, done=1.
- IDLE/DONE with start=1 -> RUN. On this transition:
  - Latch M sign-extended to WIDTH+1 bits.
  - Q <= multiplier; A (WIDTH+1 bits) <= 0; q_1 <= 0; counter <= WIDTH.
- IDLE with start=0 -> stays in IDLE.
- DONE with start=0 -> IDLE.
- RUN, each cycle, on the pair {Q[0], q_1}:
  - 10: A <= A - M.
  - 01: A <= A + M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_1} by one, with the MSB of A replicated; counter decrements.
- RUN with counter==1 at the edge -> DONE. On the same edge, product <= low 2*WIDTH bits of the post-shift {A, Q}.
- A is WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) cannot overflow. Product is exact for all operand pairs, including (-2^(WIDTH-1))^2.
- Timing: start accepted at edge 0.
  - busy=1 for cycles 1..WIDTH.
  - done=1 and product valid in cycle WIDTH+1.
  - Latency WIDTH+1 cycles; throughput one result per WIDTH+1 cycles with back-to-back starts.
- busy = (state==RUN). done = (state==DONE). Both are registered outputs, with no combinational path from the inputs.
- start while busy=1 is ignored: not queued, operands not re-sampled.
- start in the DONE cycle is accepted, and the next RUN begins the following cycle. product keeps the old result until the new DONE, then updates.
- Operand inputs may change freely after the accepting edge.
- product is updated only on the RUN->DONE transition or by reset.

Test Plan:
- WIDTH=8, reset then start with M=3, Q=5 -> busy high for 8 cycles, done pulse on cycle 9 after start, product=16'h000F; product holds 16'h000F for 20 idle cycles afterwards.
- WIDTH=8, signed and boundary cases:
  - M=-7, Q=6 -> product=16'hFFD6.
  - M=-128, Q=-128 -> product=16'h4000.
  - M=127, Q=-128 -> product=16'hC080.
  - M=0, Q=-1 -> product=16'h0000.
- WIDTH=8, M=10, Q=10, then pulse start with M=2, Q=2 on cycle 4 while busy -> second request ignored, product=16'h0064. Then start with M=-1, Q=-1 held high in the done cycle -> accepted back-to-back, next done after 9 cycles with product=16'h0001.
- WIDTH=8, start with M=50, Q=50, assert rst on cycle 5 -> next cycle busy=0, done=0, product=0, no done pulse ever appears. A fresh start with M=-2, Q=3 -> product=16'hFFFA.
- WIDTH=4 instance: M=-8, Q=-8 -> product=8'h40; M=7, Q=-8 -> product=8'hC8; latency 5 cycles.
- Randomised check: 1000 random signed operand pairs at WIDTH=8 and WIDTH=16, each compared against a $signed reference product, with latency checked to be exactly WIDTH+1.

Source files
------------

// File: rtl/booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_seq
// Description : Sequential radix-2 Booth multiplier for signed WIDTH-bit
//               operands. One recoding step per clock. Uses a start/busy/done
//               handshake and produces a 2*WIDTH-bit signed product.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;

  // A and M carry one extra bit so that subtracting M = -2^(WIDTH-1)
  // cannot overflow the accumulator.
  logic [WIDTH:0]     m_reg;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_1;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     a_next;
  logic [WIDTH-1:0]   q_next;
  logic               q1_next;

  // One Booth step: add/subtract M on the recoded pair, then arithmetic shift.
  always_comb begin
    sum = a_reg;
    case ({q_reg[0], q_1})
      2'b10:   sum = a_reg - m_reg;
      2'b01:   sum = a_reg + m_reg;
      default: sum = a_reg;
    endcase
    a_next  = {sum[WIDTH], sum[WIDTH:1]};
    q_next  = {sum[0], q_reg[WIDTH-1:1]};
    q1_next = q_reg[0];
  end

  // Control FSM and datapath registers; busy/done/product are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            q_reg <= multiplier;
            a_reg <= '0;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_1   <= q1_next;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Low 2*WIDTH bits of {A,Q} hold the exact signed product.
            product <= {a_next[WIDTH-1:0], q_next};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_multiplier_seq
// Description : Self-checking bench for booth_multiplier_seq at WIDTH=4, 8
//               and 16. Directed cases plus random operands compared with a
//               plain signed-multiply reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0, busy8, done8;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] p8;

  logic        start16 = 1'b0, busy16, done16;
  logic [15:0] m16 = '0, q16 = '0;
  logic [31:0] p16;

  logic        start4 = 1'b0, busy4, done4;
  logic [3:0]  m4 = '0, q4 = '0;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(p8)
  );

  booth_multiplier_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(p16)
  );

  booth_multiplier_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .multiplicand(m4), .multiplier(q4),
    .busy(busy4), .done(done4), .product(p4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain signed multiplication.
  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q);
    logic signed [31:0] r;
    r = $signed(m) * $signed(q);
    return r[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] m, input logic [15:0] q);
    logic signed [31:0] r;
    r = $signed(m) * $signed(q);
    return r;
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] m, input logic [3:0] q);
    logic signed [31:0] r;
    r = $signed(m) * $signed(q);
    return r[7:0];
  endfunction

  // Wait for done from the given cycle index; busy must be high until then.
  task automatic wait8(input string tag, input int first, output int lat);
    lat = first;
    while (!done8 && lat < 40) begin
      check({tag, " busy"}, busy8, 1);
      tick();
      lat++;
    end
  endtask

  task automatic do8(input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp, input string tag);
    int lat;
    start8 = 1'b1; m8 = m; q8 = q;
    tick();
    start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
    wait8(tag, 1, lat);
    check({tag, " lat"}, lat, 9);
    check({tag, " done"}, done8, 1);
    check({tag, " prod"}, p8, exp);
  endtask

  task automatic do16(input logic [15:0] m, input logic [15:0] q,
                      input logic [31:0] exp, input string tag);
    int lat;
    start16 = 1'b1; m16 = m; q16 = q;
    tick();
    start16 = 1'b0; m16 = 16'($urandom); q16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 60) begin
      check({tag, " busy"}, busy16, 1);
      tick();
      lat++;
    end
    check({tag, " lat"}, lat, 17);
    check({tag, " prod"}, p16, exp);
  endtask

  task automatic do4(input logic [3:0] m, input logic [3:0] q,
                     input logic [7:0] exp, input string tag);
    int lat;
    start4 = 1'b1; m4 = m; q4 = q;
    tick();
    start4 = 1'b0; m4 = 4'($urandom); q4 = 4'($urandom);
    lat = 1;
    while (!done4 && lat < 30) begin
      check({tag, " busy"}, busy4, 1);
      tick();
      lat++;
    end
    check({tag, " lat"}, lat, 5);
    check({tag, " prod"}, p4, exp);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0]  rm8, rq8;
    logic [15:0] rm16, rq16;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst busy8", busy8, 0);
    check("rst done8", done8, 0);
    check("rst prod8", p8, 0);
    check("rst busy16", busy16, 0);
    check("rst prod16", p16, 0);
    check("rst prod4", p4, 0);
    tick();

    // Basic product and hold
    do8(8'd3, 8'd5, 16'h000F, "3x5");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold prod", p8, 16'h000F);
      check("hold done", done8, 0);
      check("hold busy", busy8, 0);
    end

    // Signed and boundary cases
    do8(8'hF9, 8'd6,  16'hFFD6, "-7x6");
    do8(8'h80, 8'h80, 16'h4000, "-128x-128");
    do8(8'h7F, 8'h80, 16'hC080, "127x-128");
    do8(8'h00, 8'hFF, 16'h0000, "0x-1");
    tick();

    // start while busy is ignored
    start8 = 1'b1; m8 = 8'd10; q8 = 8'd10;
    tick();
    start8 = 1'b0;
    repeat (3) tick();              // now in cycle 4
    start8 = 1'b1; m8 = 8'd2; q8 = 8'd2;
    check("ign busy", busy8, 1);
    tick();
    start8 = 1'b0;
    wait8("ign", 5, lat);
    check("ign lat", lat, 9);
    check("ign prod", p8, 16'h0064);
    // start held in the done cycle: back-to-back
    do8(8'hFF, 8'hFF, 16'h0001, "b2b");
    tick();

    // Reset aborts a multiplication
    start8 = 1'b1; m8 = 8'd50; q8 = 8'd50;
    tick();
    start8 = 1'b0;
    repeat (4) tick();              // cycle 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort prod", p8, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) pulses++;
    end
    check("abort pulses", pulses, 0);
    do8(8'hFE, 8'd3, 16'hFFFA, "-2x3");

    // WIDTH=4 instance
    do4(4'h8, 4'h8, 8'h40, "w4 -8x-8");
    do4(4'h7, 4'h8, 8'hC8, "w4 7x-8");

    // Random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      rm8 = 8'($urandom); rq8 = 8'($urandom);
      do8(rm8, rq8, ref8(rm8, rq8), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      rm16 = 16'($urandom); rq16 = 16'($urandom);
      do16(rm16, rq16, ref16(rm16, rq16), "rnd16");
    end
    for (int i = 0; i < 50; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom); b = 4'($urandom);
      do4(a, b, ref4(a, b), "rnd4");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
